// File: rtl/ysyx_22040759_malu.sv
// Multi-cycle ALU: single-cycle integer ops, iterative shift-add multiplier, optional
// restoring divider (built only when YSYX_22040759_MALU_DIV_EN is defined).
module ysyx_22040759_malu #(
   parameter int unsigned XLEN  = 64,
   parameter int unsigned SEL_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [XLEN-1:0]  alu_a,
   input  logic [XLEN-1:0]  alu_b,
   input  logic [SEL_W-1:0] alu_sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  alu_result
);

   localparam int unsigned SHW = $clog2(XLEN);

   localparam logic [SEL_W-1:0] OpAdd   = SEL_W'(0);
   localparam logic [SEL_W-1:0] OpSub   = SEL_W'(1);
   localparam logic [SEL_W-1:0] OpAnd   = SEL_W'(2);
   localparam logic [SEL_W-1:0] OpOr    = SEL_W'(3);
   localparam logic [SEL_W-1:0] OpXor   = SEL_W'(4);
   localparam logic [SEL_W-1:0] OpSll   = SEL_W'(5);
   localparam logic [SEL_W-1:0] OpSrl   = SEL_W'(6);
   localparam logic [SEL_W-1:0] OpSra   = SEL_W'(7);
   localparam logic [SEL_W-1:0] OpSlt   = SEL_W'(8);
   localparam logic [SEL_W-1:0] OpSltu  = SEL_W'(9);
   localparam logic [SEL_W-1:0] OpMul   = SEL_W'(10);
   localparam logic [SEL_W-1:0] OpMulhu = SEL_W'(11);
`ifdef YSYX_22040759_MALU_DIV_EN
   localparam logic [SEL_W-1:0] OpDivu  = SEL_W'(12);
   localparam logic [SEL_W-1:0] OpRemu  = SEL_W'(13);
`endif

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   state_e              state_q, state_d;
   logic [SEL_W-1:0]    sel_q, sel_d;
   logic [XLEN-1:0]     opa_q, opa_d;
   logic [2*XLEN-1:0]   prod_q, prod_d;
   logic [SHW-1:0]      cnt_q, cnt_d;
   logic [XLEN-1:0]     res_q, res_d;

   logic [SHW-1:0]      shamt;
   logic [XLEN-1:0]     single_res;
   logic                is_iter;
   logic                is_div_in;
   logic                is_div_q;
   logic [XLEN:0]       mul_sum;
   logic [2*XLEN-1:0]   mul_next;
   logic [2*XLEN-1:0]   step_next;

   assign shamt = alu_b[SHW-1:0];

   always_comb begin
      single_res = '0;
      case (alu_sel)
         OpAdd:   single_res = alu_a + alu_b;
         OpSub:   single_res = alu_a - alu_b;
         OpAnd:   single_res = alu_a & alu_b;
         OpOr:    single_res = alu_a | alu_b;
         OpXor:   single_res = alu_a ^ alu_b;
         OpSll:   single_res = alu_a << shamt;
         OpSrl:   single_res = alu_a >> shamt;
         OpSra:   single_res = $signed(alu_a) >>> shamt;
         OpSlt:   single_res = {{(XLEN-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
         OpSltu:  single_res = {{(XLEN-1){1'b0}}, alu_a < alu_b};
         default: single_res = '0;
      endcase
   end

   // Multiplier: product register holds {partial sum, remaining multiplier bits}.
   assign mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, (prod_q[0] ? opa_q : '0)};
   assign mul_next = {mul_sum, prod_q[XLEN-1:1]};

`ifdef YSYX_22040759_MALU_DIV_EN
   logic [XLEN-1:0] opb_q, opb_d;
   logic [XLEN:0]   div_shift;
   logic            div_ge;
   logic [XLEN-1:0] div_diff;
   logic [2*XLEN-1:0] div_next;

   // Divider: upper half is the partial remainder, lower half shifts dividend out, quotient in.
   assign div_shift = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
   assign div_ge    = div_shift >= {1'b0, opb_q};
   assign div_diff  = div_shift[XLEN-1:0] - opb_q;
   assign div_next  = {(div_ge ? div_diff : div_shift[XLEN-1:0]), prod_q[XLEN-2:0], div_ge};

   assign is_div_in = (alu_sel == OpDivu) || (alu_sel == OpRemu);
   assign is_div_q  = (sel_q == OpDivu) || (sel_q == OpRemu);
   assign step_next = is_div_q ? div_next : mul_next;
`else
   assign is_div_in = 1'b0;
   assign is_div_q  = 1'b0;
   assign step_next = mul_next;
`endif

   assign is_iter = (alu_sel == OpMul) || (alu_sel == OpMulhu) || is_div_in;

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      opa_d   = opa_q;
      prod_d  = prod_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
`ifdef YSYX_22040759_MALU_DIV_EN
      opb_d   = opb_q;
`endif
      case (state_q)
         StIdle: begin
            if (in_valid) begin
               sel_d = alu_sel;
               opa_d = alu_a;
`ifdef YSYX_22040759_MALU_DIV_EN
               opb_d = alu_b;
`endif
               cnt_d = '0;
               if (is_iter) begin
                  prod_d  = is_div_in ? {{XLEN{1'b0}}, alu_a} : {{XLEN{1'b0}}, alu_b};
                  state_d = StCalc;
               end else begin
                  res_d   = single_res;
                  state_d = StDone;
               end
            end
         end
         StCalc: begin
            prod_d = step_next;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == SHW'(XLEN - 1)) begin
               // Odd ops (mulhu, remu) take the upper half, even ops the lower half.
               res_d   = sel_q[0] ? step_next[2*XLEN-1:XLEN] : step_next[XLEN-1:0];
               state_d = StDone;
            end
         end
         StDone: begin
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         sel_q   <= '0;
         opa_q   <= '0;
         prod_q  <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
`ifdef YSYX_22040759_MALU_DIV_EN
         opb_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         opa_q   <= opa_d;
         prod_q  <= prod_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
`ifdef YSYX_22040759_MALU_DIV_EN
         opb_q   <= opb_d;
`endif
      end
   end

   assign in_ready   = (state_q == StIdle);
   assign out_valid  = (state_q == StDone);
   assign alu_result = res_q;

endmodule

// File: tb/tb_ysyx_22040759_malu.sv
// Self-checking bench for ysyx_22040759_malu (XLEN=64); divide expectations follow
// YSYX_22040759_MALU_DIV_EN.
module tb_ysyx_22040759_malu;

   localparam int XLEN = 64;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] alu_a = '0;
   logic [63:0] alu_b = '0;
   logic [3:0]  alu_sel = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] alu_result;

   int tests = 0;
   int fails = 0;

   ysyx_22040759_malu #(.XLEN(XLEN), .SEL_W(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
      .out_valid(out_valid), .out_ready(out_ready), .alu_result(alu_result)
   );

   always #5 clk = ~clk;

   // Reference model built from plain arithmetic on wide integers.
   function automatic logic [63:0] ref_result(input logic [3:0] sel, input logic [63:0] a,
                                              input logic [63:0] b);
      logic [127:0] p;
      p = {64'b0, a} * {64'b0, b};
      case (sel)
         4'd0:  return a + b;
         4'd1:  return a - b;
         4'd2:  return a & b;
         4'd3:  return a | b;
         4'd4:  return a ^ b;
         4'd5:  return a << b[5:0];
         4'd6:  return a >> b[5:0];
         4'd7:  return $signed(a) >>> b[5:0];
         4'd8:  return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
         4'd9:  return (a < b) ? 64'd1 : 64'd0;
         4'd10: return p[63:0];
         4'd11: return p[127:64];
`ifdef YSYX_22040759_MALU_DIV_EN
         4'd12: return (b == 0) ? '1 : a / b;
         4'd13: return (b == 0) ? a : a % b;
`endif
         default: return 64'd0;
      endcase
   endfunction

   function automatic int ref_latency(input logic [3:0] sel);
`ifdef YSYX_22040759_MALU_DIV_EN
      if (sel >= 4'd10 && sel <= 4'd13) return XLEN + 1;
`else
      if (sel == 4'd10 || sel == 4'd11) return XLEN + 1;
`endif
      return 1;
   endfunction

   // Issues one op and collects the result; lat = -1 means no result within the budget.
   task automatic do_op(input logic [3:0] sel, input logic [63:0] a, input logic [63:0] b,
                        output logic [63:0] res, output int lat, output bit busy_ok);
      busy_ok = 1'b1;
      lat = -1;
      res = '0;
      @(negedge clk);
      alu_sel = sel; alu_a = a; alu_b = b; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      for (int c = 1; c <= 200; c++) begin
         @(negedge clk);
         if (in_ready !== 1'b0) busy_ok = 1'b0;
         if (out_valid === 1'b1) begin
            lat = c;
            res = alu_result;
            out_ready = 1'b1;
            @(posedge clk);
            #1 out_ready = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || alu_result !== 64'd0) begin
         fails++;
         $display("FAIL reset: in_ready=%b out_valid=%b result=%h, want 1 0 0",
                  in_ready, out_valid, alu_result);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_alu_directed();
      logic [3:0]  sels [6] = '{4'd0, 4'd1, 4'd7, 4'd8, 4'd9, 4'd3};
      logic [63:0] as   [6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'h8000_0000_0000_0000,
                                64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h00F0};
      logic [63:0] bs   [6] = '{64'd1, 64'd1, 64'd68, 64'd1, 64'd1, 64'h0F0F};
      logic [63:0] exps [6] = '{64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hF800_0000_0000_0000,
                                64'd1, 64'd0, 64'h0FFF};
      logic [63:0] res;
      int lat;
      bit busy_ok;
      for (int i = 0; i < 6; i++) begin
         do_op(sels[i], as[i], bs[i], res, lat, busy_ok);
         tests++;
         if (res !== exps[i] || lat != 1) begin
            fails++;
            $display("FAIL alu_op%0d: result=%h cycle=%0d, want %h at cycle 1",
                     sels[i], res, lat, exps[i]);
         end
      end
   endtask

   task automatic test_mul();
      logic [63:0] res;
      int lat;
      bit busy_ok;
      for (int i = 0; i < 2; i++) begin
         logic [3:0] sel;
         logic [63:0] exp;
         sel = (i == 0) ? 4'd10 : 4'd11;
         exp = (i == 0) ? 64'hFFFF_FFFF_FFFF_FFFE : 64'd1;
         do_op(sel, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, res, lat, busy_ok);
         tests++;
         if (res !== exp || lat != 65 || !busy_ok) begin
            fails++;
            $display("FAIL mul_op%0d: result=%h cycle=%0d busy_ok=%b, want %h at 65 busy 1",
                     sel, res, lat, busy_ok, exp);
         end
      end
   endtask

   task automatic test_div();
      logic [3:0]  sels [4] = '{4'd12, 4'd13, 4'd12, 4'd13};
      logic [63:0] as   [4] = '{64'd100, 64'd100, 64'd5, 64'd5};
      logic [63:0] bs   [4] = '{64'd7, 64'd7, 64'd0, 64'd0};
`ifdef YSYX_22040759_MALU_DIV_EN
      logic [63:0] exps [4] = '{64'd14, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5};
      int          want_lat = 65;
`else
      logic [63:0] exps [4] = '{64'd0, 64'd0, 64'd0, 64'd0};
      int          want_lat = 1;
`endif
      logic [63:0] res;
      int lat;
      bit busy_ok;
      for (int i = 0; i < 4; i++) begin
         do_op(sels[i], as[i], bs[i], res, lat, busy_ok);
         tests++;
         if (res !== exps[i] || lat != want_lat) begin
            fails++;
            $display("FAIL div_op%0d_%0d_%0d: result=%h cycle=%0d, want %h at %0d",
                     sels[i], as[i], bs[i], res, lat, exps[i], want_lat);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [63:0] a, b, exp;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      exp = ref_result(4'd1, a, b);
      @(negedge clk);
      alu_sel = 4'd1; alu_a = a; alu_b = b; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         tests++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || alu_result !== exp) begin
            fails++;
            $display("FAIL hold_c%0d: out_valid=%b in_ready=%b result=%h, want 1 0 %h",
                     c, out_valid, in_ready, alu_result, exp);
         end
         alu_sel = 4'd0; alu_a = {$urandom, $urandom}; alu_b = 64'd3; in_valid = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         fails++;
         $display("FAIL hold_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_abort();
      logic [63:0] res;
      int lat;
      bit busy_ok;
      @(negedge clk);
      alu_sel = 4'd10; alu_a = 64'h1234_5678; alu_b = 64'h9ABC; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (30) @(negedge clk);
      rst = 1'b1;
      #1;
      tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || alu_result !== 64'd0) begin
         fails++;
         $display("FAIL abort: in_ready=%b out_valid=%b result=%h, want 1 0 0",
                  in_ready, out_valid, alu_result);
      end
      @(negedge clk);
      rst = 1'b0;
      do_op(4'd10, 64'hDEAD_BEEF_0000_0001, 64'h0000_0001_0000_0003, res, lat, busy_ok);
      tests++;
      if (res !== ref_result(4'd10, 64'hDEAD_BEEF_0000_0001, 64'h0000_0001_0000_0003) ||
          lat != 65) begin
         fails++;
         $display("FAIL mul_after_abort: result=%h cycle=%0d", res, lat);
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] q[$];
      int n_acc = 0;
      out_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (out_valid === 1'b1) begin
            logic [63:0] exp;
            exp = (q.size() > 0) ? q.pop_front() : 64'hx;
            tests++;
            if (alu_result !== exp) begin
               fails++;
               $display("FAIL b2b_c%0d: result=%h, want %h", c, alu_result, exp);
            end
         end
         if (in_ready === 1'b1) begin
            alu_sel = 4'($urandom_range(0, 9));
            alu_a = {$urandom, $urandom};
            alu_b = {$urandom, $urandom};
            in_valid = 1'b1;
            q.push_back(ref_result(alu_sel, alu_a, alu_b));
            n_acc++;
         end else begin
            in_valid = 1'b0;
         end
      end
      @(posedge clk);
      #1 out_ready = 1'b0;
      in_valid = 1'b0;
      tests++;
      if (n_acc != 5 || q.size() != 0) begin
         fails++;
         $display("FAIL b2b_rate: accepts=%0d pending=%0d, want 5 0", n_acc, q.size());
      end
   endtask

   task automatic test_random();
      logic [63:0] res, a, b;
      logic [3:0]  sel;
      int lat;
      bit busy_ok;
      for (int i = 0; i < 30; i++) begin
         sel = 4'($urandom_range(0, 15));
         a = {$urandom, $urandom};
         case ($urandom_range(0, 7))
            0:       b = 64'd0;
            1:       b = 64'($urandom_range(1, 100));
            default: b = {$urandom, $urandom};
         endcase
         do_op(sel, a, b, res, lat, busy_ok);
         tests++;
         if (res !== ref_result(sel, a, b) || lat != ref_latency(sel) || !busy_ok) begin
            fails++;
            $display("FAIL rand%0d_op%0d: a=%h b=%h result=%h cycle=%0d, want %h at %0d",
                     i, sel, a, b, res, lat, ref_result(sel, a, b), ref_latency(sel));
         end
      end
   endtask

   initial begin
      test_reset();
      test_alu_directed();
      test_mul();
      test_div();
      test_backpressure();
      test_abort();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
